// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, fetch FSM states and small helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_VALID
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// PC register and next-fetch-PC mux for the fetch stage.
// IFETCH_JUMP_EN adds J-type redirect on consumption.
module pc_next
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        consume,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef IFETCH_JUMP_EN
  input  logic [31:0] instr,
`endif
  output logic [31:0] fetch_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_pc;
  logic        jump;

  assign seq_pc = pc_q + 32'd4;

`ifdef IFETCH_JUMP_EN
  assign jump = (instr[31:26] == OP_J);
`else
  assign jump = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (capture) begin
      pc_d = fetch_pc_q;
    end
    // branch_taken only matters when the held instruction is consumed
    if (consume) begin
      unique case (1'b1)
`ifdef IFETCH_JUMP_EN
        jump:
          fetch_pc_d = {seq_pc[31:28], instr[25:0], 2'b00};
`endif
        (!jump && branch_taken):
          fetch_pc_d = word_align(branch_target);
        default:
          fetch_pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc = fetch_pc_q;
  assign pc       = pc_q;
  assign pc_plus4 = seq_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/REQ/VALID FSM plus instruction register.
// Define IFETCH_JUMP_EN to resolve J-type jumps inside fetch.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  fetch_state_e state_q, state_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic         capture;
  logic         consume;

  assign capture = (state_q == FS_REQ) && imem_ready;
  assign consume = (state_q == FS_VALID) && !stall;

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    unique case (state_q)
      FS_IDLE: begin
        state_d    = FS_REQ;
        imem_req_d = 1'b1;
      end
      FS_REQ: begin
        if (imem_ready) begin
          state_d       = FS_VALID;
          instr_d       = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
        end
      end
      FS_VALID: begin
        if (!stall) begin
          state_d       = FS_REQ;
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = FS_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FS_IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
    end
  end

  pc_next #(
    .RESET_PC(RESET_PC)
  ) u_pc_next (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .consume      (consume),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
`ifdef IFETCH_JUMP_EN
    .instr        (instr_q),
`endif
    .fetch_pc     (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch, plus a RESET_PC wrap instance.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ready, stall, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;

  logic        b_rst_n, b_ready;
  logic [31:0] b_rdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc, b_pc4;
  logic [5:0]  b_opcode;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(b_rst_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rdata(b_rdata),
    .instr(b_instr), .opcode(b_opcode), .instr_valid(b_valid),
    .pc(b_pc), .pc_plus4(b_pc4), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0)
  );

`ifdef IFETCH_JUMP_EN
  localparam logic [31:0] JADDR = 32'h1000_0040;
`else
  localparam logic [31:0] JADDR = 32'h1000_0004;
`endif

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        bt;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic rd, input logic [31:0] da,
                   input logic s, input logic b, input logic [31:0] t,
                   input logic q, input logic [31:0] a, input logic vl,
                   input logic [31:0] p, input logic [31:0] in);
    vec_t e;
    e.rst_n = r; e.rdy = rd; e.rdata = da; e.stall = s;
    e.bt = b; e.tgt = t; e.req = q; e.addr = a; e.vld = vl;
    e.pc = p; e.instr = in;
    vq.push_back(e);
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; imem_rdata = 0; stall = 0;
    branch_taken = 0; branch_target = 0;
    b_rst_n = 0; b_ready = 0; b_rdata = 0;

    // reset, then zero-wait fetches 0x0, 0x4, 0x8
    v(0,0,32'h0,0,0,32'h0,        0,32'h0,0,32'h0,32'h0);
    v(1,0,32'h0,0,0,32'h0,        1,32'h0,0,32'h0,32'h0);
    v(1,1,32'hAAAA0001,0,0,32'h0, 0,32'h0,1,32'h0,32'hAAAA0001);
    v(1,0,32'h0,0,0,32'h0,        1,32'h4,0,32'h0,32'hAAAA0001);
    v(1,1,32'h11110002,0,0,32'h0, 0,32'h4,1,32'h4,32'h11110002);
    v(1,0,32'h0,0,0,32'h0,        1,32'h8,0,32'h4,32'h11110002);
    v(1,1,32'h22220003,0,0,32'h0, 0,32'h8,1,32'h8,32'h22220003);
    // wait states at 0xC
    v(1,0,32'h0,0,0,32'h0,        1,32'hC,0,32'h8,32'h22220003);
    v(1,0,32'h0,0,0,32'h0,        1,32'hC,0,32'h8,32'h22220003);
    v(1,0,32'h0,0,0,32'h0,        1,32'hC,0,32'h8,32'h22220003);
    v(1,0,32'h0,0,0,32'h0,        1,32'hC,0,32'h8,32'h22220003);
    v(1,1,32'h33330004,0,0,32'h0, 0,32'hC,1,32'hC,32'h33330004);
    // stall with branch pending, stray ready ignored
    v(1,1,32'hDEAD0000,1,1,32'h43,0,32'hC,1,32'hC,32'h33330004);
    v(1,0,32'h0,1,1,32'h43,       0,32'hC,1,32'hC,32'h33330004);
    v(1,0,32'h0,0,1,32'h43,       1,32'h40,0,32'hC,32'h33330004);
    // branch_taken in REQ ignored
    v(1,1,32'h8C000000,0,1,32'h100,0,32'h40,1,32'h40,32'h8C000000);
    v(1,0,32'h0,0,1,32'h10000000, 1,32'h10000000,0,32'h40,32'h8C000000);
    v(1,1,32'h08000010,0,0,32'h0, 0,32'h10000000,1,32'h10000000,32'h08000010);
    v(1,0,32'h0,0,0,32'h0,        1,JADDR,0,32'h10000000,32'h08000010);
    // reset in REQ, ready in IDLE ignored
    v(0,0,32'h0,0,0,32'h0,        0,32'h0,0,32'h0,32'h0);
    v(1,1,32'h0000BEEF,0,0,32'h0, 1,32'h0,0,32'h0,32'h0);
    v(1,1,32'h00001234,0,0,32'h0, 0,32'h0,1,32'h0,32'h00001234);
    v(1,0,32'h0,0,0,32'h0,        1,32'h4,0,32'h0,32'h00001234);
    v(1,1,32'h00005678,0,0,32'h0, 0,32'h4,1,32'h4,32'h00005678);
    v(1,0,32'h0,0,0,32'h0,        1,32'h8,0,32'h4,32'h00005678);
    v(0,1,32'hFFFFFFFF,0,0,32'h0, 0,32'h0,0,32'h0,32'h0);
    v(1,0,32'h0,0,0,32'h0,        1,32'h0,0,32'h0,32'h0);
    v(1,1,32'h00000009,0,0,32'h0, 0,32'h0,1,32'h0,32'h00000009);
    // reset in VALID
    v(0,0,32'h0,0,0,32'h0,        0,32'h0,0,32'h0,32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      logic [31:0] e4;
      @(negedge clk);
      rst_n = vq[i].rst_n; imem_ready = vq[i].rdy;
      imem_rdata = vq[i].rdata; stall = vq[i].stall;
      branch_taken = vq[i].bt; branch_target = vq[i].tgt;
      @(posedge clk);
      #1;
      e4 = vq[i].pc + 32'd4;
      chk($sformatf("v%0d.req", i), {31'h0, imem_req}, {31'h0, vq[i].req});
      chk($sformatf("v%0d.addr", i), imem_addr, vq[i].addr);
      chk($sformatf("v%0d.vld", i), {31'h0, instr_valid}, {31'h0, vq[i].vld});
      chk($sformatf("v%0d.pc", i), pc, vq[i].pc);
      chk($sformatf("v%0d.pc4", i), pc_plus4, e4);
      chk($sformatf("v%0d.instr", i), instr, vq[i].instr);
      chk($sformatf("v%0d.opc", i), {26'h0, opcode},
          {26'h0, vq[i].instr[31:26]});
    end

    // RESET_PC wrap instance
    @(negedge clk); b_rst_n = 1;
    @(posedge clk); #1;
    chk("wrap.req1", {31'h0, b_req}, 32'h1);
    chk("wrap.addr1", b_addr, 32'hFFFF_FFFC);
    @(negedge clk); b_ready = 1; b_rdata = 32'h0000_0042;
    @(posedge clk); #1;
    chk("wrap.vld", {31'h0, b_valid}, 32'h1);
    chk("wrap.pc", b_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", b_pc4, 32'h0);
    @(negedge clk); b_ready = 0;
    @(posedge clk); #1;
    chk("wrap.addr2", b_addr, 32'h0);
    chk("wrap.req2", {31'h0, b_req}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first instruction address after reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-004 Port imem_req, output, 1 bit, SHALL be the instruction memory read request.
REQ-005 Port imem_addr, output, 32 bits, SHALL be the read address, word aligned.
REQ-006 Port imem_ready, input, 1 bit, SHALL mean imem_rdata is valid this cycle.
REQ-007 Port imem_rdata, input, 32 bits, SHALL be the instruction word returned by memory.
REQ-008 Port instr, output, 32 bits, SHALL be the held instruction for the decoder.
REQ-009 Port opcode, output, 6 bits, SHALL be instr[31:26], the control decoder input.
REQ-010 Port instr_valid, output, 1 bit, SHALL mean instr/opcode/pc are valid.
REQ-011 Port pc, output, 32 bits, SHALL be the address of the held instruction.
REQ-012 Port pc_plus4, output, 32 bits, SHALL be pc + 4, modulo 2^32.
REQ-013 Port stall, input, 1 bit, SHALL mean the datapath cannot consume the held instruction.
REQ-014 Port branch_taken, input, 1 bit, SHALL mean Branch AND ALU zero for the held instruction.
REQ-015 Port branch_target, input, 32 bits, SHALL be the resolved branch address.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and VALID.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 In REQ: imem_req = 1, imem_addr = fetch PC; on imem_ready, capture imem_rdata into instr, set pc = fetch PC, go to VALID.
REQ-019 In REQ without imem_ready: stay in REQ; imem_addr SHALL hold stable.
REQ-020 In VALID: instr_valid = 1, imem_req = 0; instr and pc SHALL hold while stall = 1.
REQ-021 In VALID with stall = 0 the instruction is consumed: next fetch PC = branch_target[31:2],2'b00 if branch_taken, else pc_plus4; go to REQ.
REQ-022 branch_taken SHALL be ignored unless instr_valid = 1 and stall = 0 in the same cycle.
REQ-023 branch_target[1:0] SHALL be forced to 2'b00.
REQ-024 pc_plus4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-025 imem_ready outside REQ SHALL be ignored, with no state change.
REQ-026 Minimum latency SHALL be 1 cycle from imem_ready in REQ to instr_valid; sustained throughput SHALL be one instruction per 2 cycles with zero-wait memory.

Reset
REQ-027 With rst_n = 0 at a clock edge: state = IDLE, fetch PC = RESET_PC, pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, imem_addr = RESET_PC.
REQ-028 Reset during REQ or VALID SHALL abort the access; imem_req SHALL be 0 the cycle after the reset edge.

Configuration
REQ-029 With macro IFETCH_JUMP_EN defined, on consumption of an opcode 6'b000010 instruction, next fetch PC SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}; branch_taken SHALL be ignored for that instruction.
REQ-030 Without IFETCH_JUMP_EN, opcode 6'b000010 SHALL be treated like any other non-branch instruction (next PC = pc_plus4).

Structure
REQ-031 Opcode constants (R-type, LW, SW, BEQ, J) and the fetch state enum SHALL live in shared package mips_pkg.
REQ-032 The PC register and next-PC mux SHALL be sub-module pc_next; the FSM and instruction register SHALL stay in instr_fetch.

Verification
REQ-033 Reset, then imem_ready = 1 in every REQ cycle -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle.
REQ-034 imem_ready held low 3 cycles in REQ -> imem_req stays 1; imem_addr stays 0x4; instr_valid = 0 until the cycle after ready.
REQ-035 pc = 0x10, stall = 1 for 2 cycles with branch_taken = 1 -> instr/pc hold; branch applies only on the stall = 0 cycle; target 0x43 -> next imem_addr 0x40.
REQ-036 RESET_PC = 32'hFFFF_FFFC -> second fetch address 0x0 (wrap).
REQ-037 rst_n low during REQ with addr 0x8 -> next cycle imem_req = 0; after release, first fetch from RESET_PC.
REQ-038 IFETCH_JUMP_EN defined, pc = 0x1000_0000, instr = 32'h0800_0010 -> next imem_addr 0x1000_0040; macro undefined -> 0x1000_0004.
